// File: rtl/sha256_miner_pkg.sv
// Shared constants and types for the SHA-256 work sequencer and its golden-nonce FIFO.
package sha256_miner_pkg;

  // Second-block padding above the nonce: 0x80 terminator, zeros, 640-bit message length.
  localparam logic [383:0] PAD_384 =
    384'h000002800000000000000000000000000000000000000000000000000000000000000000000000000000000080000000;

  // Bits of hash word 7 that must all be zero for a golden result.
  localparam logic [31:0] GOLDEN_MASK = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [31:0] nonce;
    logic        gen;
  } golden_entry_t;

  typedef struct packed {
    logic          valid;
    golden_entry_t entry;
  } track_entry_t;

endpackage

// File: rtl/sha256_work_sequencer_golden_fifo.sv
// Two-entry valid/ready FIFO for golden nonces; the head register drives the outputs directly.
module golden_fifo
  import sha256_miner_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  golden_entry_t push_entry,
  input  logic          out_ready,
  output logic          out_valid,
  output golden_entry_t out_entry,
  output logic          overflow
);

  golden_entry_t head_q, tail_q;
  logic          head_v_q, tail_v_q, overflow_q;
  logic          pop;

  assign pop = head_v_q && out_ready;

  // NOTE: the data registers are reset too, because the head feeds outputs that must read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_v_q   <= 1'b0;
      tail_v_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (pop) begin
      head_q   <= tail_v_q ? tail_q : (push ? push_entry : head_q);
      head_v_q <= tail_v_q || push;
      tail_v_q <= tail_v_q && push;
      if (tail_v_q && push) tail_q <= push_entry;
    end else if (push) begin
      if (!head_v_q) begin
        head_q   <= push_entry;
        head_v_q <= 1'b1;
      end else if (!tail_v_q) begin
        tail_q   <= push_entry;
        tail_v_q <= 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_valid = head_v_q;
  assign out_entry = head_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/sha256_work_sequencer.sv
// Work sequencer around sha256_transform: loads work, issues nonces once per loop and reports golden nonces.
module sha256_work_sequencer
  import sha256_miner_pkg::*;
#(
  parameter int          LOOP         = 4,
  parameter int          RESULT_DELAY = 200,
  parameter logic [31:0] NONCE_START  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_tail,
  output logic         hash_feedback,
  output logic [5:0]   hash_cnt,
  output logic [255:0] hash_state,
  output logic [511:0] hash_input,
  input  logic [255:0] hash_result,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic [31:0]  golden_nonce,
  output logic         golden_gen,
  output logic         exhausted,
  output logic         overflow
);

  localparam int            CW       = (LOOP > 1) ? $clog2(LOOP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOOP - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [255:0]  mid_q, pend_mid_q;
  logic [95:0]   tail_q, pend_tail_q;
  logic [31:0]   nonce_q;
  logic          pend_q, gen_q, last_q;
  logic          accept, cnt_last, issue, last_now, load, candidate;
  golden_entry_t golden_q;
  track_entry_t  dl_q [RESULT_DELAY];
  logic          unused_hash;

  assign work_ready = 1'b1;
  assign accept     = work_valid && work_ready;
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign issue      = (state_q == ST_RUN) && (cnt_q == '0);
  assign last_now   = last_q || (issue && (nonce_q == 32'hFFFF_FFFF));
  // New work only lands where the next cycle starts a fresh loop, so a running loop finishes on old data.
  assign load       = ((state_q != ST_RUN) || cnt_last) && (accept || pend_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next-state is assigned a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = ST_RUN;
      ST_RUN:           if (cnt_last && last_now && !load) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      mid_q       <= '0;
      tail_q      <= '0;
      pend_mid_q  <= '0;
      pend_tail_q <= '0;
      pend_q      <= 1'b0;
      nonce_q     <= '0;
      gen_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_RUN && state_d == ST_RUN && !cnt_last) ? cnt_q + 1'b1 : '0;
      if (load) begin
        mid_q   <= accept ? work_midstate : pend_mid_q;
        tail_q  <= accept ? work_tail : pend_tail_q;
        nonce_q <= NONCE_START;
        gen_q   <= ~gen_q;
        last_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        if (accept) begin
          pend_mid_q  <= work_midstate;
          pend_tail_q <= work_tail;
          pend_q      <= 1'b1;
        end
        if (issue) begin
          nonce_q <= nonce_q + 32'd1;
          if (nonce_q == 32'hFFFF_FFFF) last_q <= 1'b1;
        end
      end
    end
  end

  // Tracks every cycle so the tail entry lines up exactly with the transform's tx_hash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RESULT_DELAY; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{valid: issue, entry: '{nonce: nonce_q, gen: gen_q}};
      for (int i = 1; i < RESULT_DELAY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign candidate   = dl_q[RESULT_DELAY-1].valid && ((hash_result[255:224] & GOLDEN_MASK) == '0);
  assign unused_hash = ^hash_result[223:0];

  golden_fifo u_golden_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (candidate),
    .push_entry (dl_q[RESULT_DELAY-1].entry),
    .out_ready  (golden_ready),
    .out_valid  (golden_valid),
    .out_entry  (golden_q),
    .overflow   (overflow)
  );

  assign golden_nonce  = golden_q.nonce;
  assign golden_gen    = golden_q.gen;
  assign hash_cnt      = 6'(cnt_q);
  assign hash_feedback = (cnt_q != '0);
  assign hash_state    = mid_q;
  assign hash_input    = (state_q == ST_IDLE) ? '0 : {PAD_384, nonce_q, tail_q};
  assign exhausted     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha256_work_sequencer.sv
// Directed bench: two sequencers (nonce start 0 and FFFFFFFE) with a cycle-indexed hash_result stub.
module tb_sha256_work_sequencer;

  localparam logic [383:0] EXP_PAD =
    384'h000002800000000000000000000000000000000000000000000000000000000000000000000000000000000080000000;
  localparam logic [255:0] GOLD   = {32'h0000_0000, {224{1'b1}}};
  localparam logic [255:0] NOGOLD = {32'h0000_0001, {224{1'b1}}};
  localparam logic [255:0] M1 = {8{32'h1111_0001}};
  localparam logic [255:0] M2 = {8{32'h2222_0002}};
  localparam logic [255:0] M3 = {8{32'h3333_0003}};
  localparam logic [95:0]  T1 = 96'h0A0B0C0D_11223344_55667788;
  localparam logic [95:0]  T2 = 96'hCAFEF00D_DEADBEEF_01020304;
  localparam logic [95:0]  T3 = 96'h13579BDF_2468ACE0_0F1E2D3C;
  localparam logic [95:0]  T4 = 96'h99887766_55443322_11000FF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, wv_a, wr_a, fb_a, gr_a, gv_a, gg_a, exh_a, ovf_a;
  logic [255:0] mid_a, st_a, hash_a;
  logic [95:0]  tail_a;
  logic [5:0]   cnt_a;
  logic [511:0] in_a;
  logic [31:0]  gn_a;
  logic         rst_b, wv_b, wr_b, fb_b, gr_b, gv_b, gg_b, exh_b, ovf_b;
  logic [255:0] mid_b, st_b, hash_b;
  logic [95:0]  tail_b;
  logic [5:0]   cnt_b;
  logic [511:0] in_b;
  logic [31:0]  gn_b;

  sha256_work_sequencer #(.LOOP(4), .RESULT_DELAY(10), .NONCE_START(32'h0000_0000)) dut_a (
    .clk(clk), .reset(rst_a), .work_valid(wv_a), .work_ready(wr_a), .work_midstate(mid_a),
    .work_tail(tail_a), .hash_feedback(fb_a), .hash_cnt(cnt_a), .hash_state(st_a),
    .hash_input(in_a), .hash_result(hash_a), .golden_valid(gv_a), .golden_ready(gr_a),
    .golden_nonce(gn_a), .golden_gen(gg_a), .exhausted(exh_a), .overflow(ovf_a)
  );

  sha256_work_sequencer #(.LOOP(4), .RESULT_DELAY(10), .NONCE_START(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .reset(rst_b), .work_valid(wv_b), .work_ready(wr_b), .work_midstate(mid_b),
    .work_tail(tail_b), .hash_feedback(fb_b), .hash_cnt(cnt_b), .hash_state(st_b),
    .hash_input(in_b), .hash_result(hash_b), .golden_valid(gv_b), .golden_ready(gr_b),
    .golden_nonce(gn_b), .golden_gen(gg_b), .exhausted(exh_b), .overflow(ovf_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit flag_a [0:1023];
  bit flag_b [0:1023];

  // Edge counter plus hash stub: a flagged edge index makes hash_result golden for that one cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    hash_a = (cyc < 1024 && flag_a[cyc]) ? GOLD : NOGOLD;
    hash_b = (cyc < 1024 && flag_b[cyc]) ? GOLD : NOGOLD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, wr_a, 1'b1);
    check({tag, "_fb"}, fb_a, 1'b0);
    check({tag, "_cnt"}, cnt_a, 6'd0);
    check({tag, "_state"}, st_a, 256'd0);
    check({tag, "_input"}, in_a, 512'd0);
    check({tag, "_gv"}, gv_a, 1'b0);
    check({tag, "_gn"}, gn_a, 32'd0);
    check({tag, "_gg"}, gg_a, 1'b0);
    check({tag, "_exh"}, exh_a, 1'b0);
    check({tag, "_ovf"}, ovf_a, 1'b0);
  endtask

  typedef struct {
    logic [5:0]  cnt;
    logic        fb;
    logic        chk_nonce;
    logic [31:0] nonce;
  } seq_vec_t;

  seq_vec_t vec [5];
  int e, f, g;

  initial begin
    vec[0] = '{6'd0, 1'b0, 1'b1, 32'd0};
    vec[1] = '{6'd1, 1'b1, 1'b0, 32'd0};
    vec[2] = '{6'd2, 1'b1, 1'b0, 32'd0};
    vec[3] = '{6'd3, 1'b1, 1'b0, 32'd0};
    vec[4] = '{6'd0, 1'b0, 1'b1, 32'd1};

    rst_a = 1'b1; rst_b = 1'b1; wv_a = 1'b0; wv_b = 1'b0; gr_a = 1'b1; gr_b = 1'b1;
    mid_a = '0; tail_a = '0; mid_b = '0; tail_b = '0;
    hash_a = NOGOLD; hash_b = NOGOLD;
    repeat (3) step();
    check_reset_a("por");
    check("b_por_ready", wr_b, 1'b1);
    check("b_por_exh", exh_b, 1'b0);
    check("b_por_gv", gv_b, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Work load on A; first issue follows the accept edge directly.
    wv_a = 1'b1; mid_a = M1; tail_a = T1;
    step();
    wv_a = 1'b0;
    e = cyc;
    flag_a[e+30] = 1'b1;  // nonce 5
    flag_a[e+50] = 1'b1;  // nonce 10
    flag_a[e+54] = 1'b1;  // nonce 11
    flag_a[e+58] = 1'b1;  // nonce 12
    flag_a[e+74] = 1'b1;  // nonce 16, old work
    flag_a[e+78] = 1'b1;  // nonce 0, new work
    check("a_state", st_a, M1);
    check("a_tail", in_a[95:0], T1);
    check("a_pad", in_a[511:128], EXP_PAD);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("a_cnt[%0d]", i), cnt_a, vec[i].cnt);
      check($sformatf("a_fb[%0d]", i), fb_a, vec[i].fb);
      if (vec[i].chk_nonce) check($sformatf("a_nonce[%0d]", i), in_a[127:96], vec[i].nonce);
      step();
    end

    // Only nonce 5 is reported, one cycle after its result cycle.
    while (cyc <= e + 40) begin
      check($sformatf("a_gv@%0d", cyc - e), gv_a, (cyc == e + 31));
      if (cyc == e + 31) begin
        check("a_gn5", gn_a, 32'd5);
        check("a_gg5", gg_a, 1'b1);
      end
      step();
    end

    // Three back-to-back candidates with the consumer stalled.
    gr_a = 1'b0;
    goto(e + 58);
    check("a_ovf_pre", ovf_a, 1'b0);
    check("a_gv_full", gv_a, 1'b1);
    step();
    check("a_ovf_set", ovf_a, 1'b1);
    check("a_head10", gn_a, 32'd10);
    gr_a = 1'b1;
    step();
    check("a_gv_11", gv_a, 1'b1);
    check("a_head11", gn_a, 32'd11);
    step();
    check("a_gv_empty", gv_a, 1'b0);
    check("a_ovf_sticky", ovf_a, 1'b1);

    // New work accepted at cnt==2 waits for the loop boundary.
    goto(e + 66);
    check("a_mid_cnt2", cnt_a, 6'd2);
    wv_a = 1'b1; mid_a = M2; tail_a = T2;
    step();
    wv_a = 1'b0;
    check("a_mid_cnt3", cnt_a, 6'd3);
    check("a_mid_oldtail", in_a[95:0], T1);
    check("a_mid_oldstate", st_a, M1);
    step();
    check("a_mid_cnt0", cnt_a, 6'd0);
    check("a_mid_newtail", in_a[95:0], T2);
    check("a_mid_newnonce", in_a[127:96], 32'd0);
    check("a_mid_newstate", st_a, M2);
    goto(e + 75);
    check("a_old_gv", gv_a, 1'b1);
    check("a_old_gn", gn_a, 32'd16);
    check("a_old_gg", gg_a, 1'b1);
    step();
    check("a_old_popped", gv_a, 1'b0);
    goto(e + 79);
    check("a_new_gv", gv_a, 1'b1);
    check("a_new_gn", gn_a, 32'd0);
    check("a_new_gg", gg_a, 1'b0);

    // Asynchronous reset in the middle of a run, with golden hashes offered throughout.
    goto(e + 82);
    for (int n = e + 83; n <= e + 110; n++) flag_a[n] = 1'b1;
    rst_a = 1'b1;
    #1;
    check_reset_a("midrun");
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("a_post_gv[%0d]", i), gv_a, 1'b0);
      check($sformatf("a_post_cnt[%0d]", i), cnt_a, 6'd0);
    end

    // B: start two nonces from the end of the space, run to exhaustion.
    wv_b = 1'b1; mid_b = M3; tail_b = T3;
    step();
    wv_b = 1'b0;
    f = cyc;
    flag_b[f+14] = 1'b1;  // nonce FFFFFFFF
    for (int r = 0; r <= 12; r++) begin
      check($sformatf("b_cnt[%0d]", r), cnt_b, (r < 8) ? 6'(r % 4) : 6'd0);
      check($sformatf("b_exh[%0d]", r), exh_b, (r >= 8));
      if (r == 0) check("b_nonce_fe", in_b[127:96], 32'hFFFF_FFFE);
      if (r == 4) check("b_nonce_ff", in_b[127:96], 32'hFFFF_FFFF);
      step();
    end
    goto(f + 15);
    check("b_gv_ff", gv_b, 1'b1);
    check("b_gn_ff", gn_b, 32'hFFFF_FFFF);
    check("b_gg_ff", gg_b, 1'b1);
    step();
    check("b_gv_popped", gv_b, 1'b0);
    wv_b = 1'b1; tail_b = T4;
    step();
    wv_b = 1'b0;
    g = cyc;
    flag_b[g+10] = 1'b1;  // nonce FFFFFFFE of the new work
    check("b_reload_exh", exh_b, 1'b0);
    check("b_reload_cnt", cnt_b, 6'd0);
    check("b_reload_nonce", in_b[127:96], 32'hFFFF_FFFE);
    check("b_reload_tail", in_b[95:0], T4);
    goto(g + 11);
    check("b_gv_new", gv_b, 1'b1);
    check("b_gn_new", gn_b, 32'hFFFF_FFFE);
    check("b_gg_new", gg_b, 1'b0);
    check("b_ovf", ovf_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
